// File: rtl/decoder_pipe_if.sv
// decoder_pipe_if: val/rdy/msg handshake channel.
// The producer side uses master, the consumer side uses slave.
interface decoder_pipe_if #(
   parameter int W = 8
);
   logic         val;
   logic         rdy;
   logic [W-1:0] msg;

   modport master (
      output val,
      output msg,
      input  rdy
   );

   modport slave (
      input  val,
      input  msg,
      output rdy
   );
endinterface

// File: rtl/decoder_pipe.sv
// decoder_pipe: registered val/rdy index decoder (one-hot, thermometer, accumulate).
// Define DECODER_PIPE_RANGE_EN to add the err port and out-of-range squashing.
module decoder_pipe #(
   parameter int m = 3,
   parameter int n = 1 << m
) (
   input  logic           clk,
   input  logic           reset,
   decoder_pipe_if.slave  recv,
   decoder_pipe_if.master send,
   input  logic [1:0]     mode,
   input  logic           clear
`ifdef DECODER_PIPE_RANGE_EN
   ,
   output logic           err
`endif
);

   logic [m-1:0] x;
   logic [n-1:0] acc;
   logic [n-1:0] acc_eff;
   logic [n-1:0] acc_nxt;
   logic [n-1:0] onehot;
   logic [n-1:0] therm;
   logic [n-1:0] dec;
   logic [n-1:0] msg;
   logic         val;
   logic         fire;

   assign x        = recv.msg;
   assign recv.rdy = !val || send.rdy;
   assign fire     = recv.val && recv.rdy;
   assign send.val = val;
   assign send.msg = msg;
   assign acc_eff  = clear ? '0 : acc;

   // Shifting past bit n-1 yields 0, so out-of-range
   // thermometer becomes 0 | (0 - 1) = all ones.
   assign onehot = n'(1) << x;
   assign therm  = onehot | (onehot - n'(1));

`ifdef DECODER_PIPE_RANGE_EN
   logic in_range;

   assign in_range = {{(32-m){1'b0}}, x} < 32'(n);

   always_comb begin
      dec     = '0;
      acc_nxt = acc_eff;
      if (in_range) begin
         unique case (mode)
            2'd0: dec = onehot;
            2'd1: dec = therm;
            2'd2: begin
               dec = acc_eff | onehot;
               if (fire) acc_nxt = dec;
            end
            2'd3: begin
               dec = onehot;
               if (fire) acc_nxt = dec;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err <= 1'b0;
      end else if (fire) begin
         err <= !in_range;
      end
   end
`else
   always_comb begin
      dec     = '0;
      acc_nxt = acc_eff;
      unique case (mode)
         2'd0: dec = onehot;
         2'd1: dec = therm;
         2'd2: begin
            dec = acc_eff | onehot;
            if (fire) acc_nxt = dec;
         end
         2'd3: begin
            dec = onehot;
            if (fire) acc_nxt = dec;
         end
      endcase
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         val <= 1'b0;
         msg <= '0;
         acc <= '0;
      end else begin
         acc <= acc_nxt;
         if (fire) begin
            val <= 1'b1;
            msg <= dec;
         end else if (send.rdy) begin
            val <= 1'b0;
         end
      end
   end

endmodule
